// File: rtl/pdp8lfpi2cq_pkg.sv
// Shared definitions for the queued front-panel I2C controller:
// register map, ID words, FSM states and FIFO entry layouts.
package pdp8lfpi2cq_pkg;

  localparam logic [2:0] REG_ID    = 3'd0;
  localparam logic [2:0] REG_CMDLO = 3'd1;
  localparam logic [2:0] REG_CMDHI = 3'd2;
  localparam logic [2:0] REG_STLO  = 3'd3;
  localparam logic [2:0] REG_STHI  = 3'd4;
  localparam logic [2:0] REG_CTL   = 3'd5;
  localparam logic [2:0] REG_HEAD  = 3'd6;
  localparam logic [2:0] REG_PAD   = 3'd7;

  localparam logic [31:0] ID_WORD  = 32'h46502010;
  localparam logic [31:0] PAD_WORD = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAITHI, S_WAITLO, S_CAPT
  } state_t;

  // command FIFO entry: target bus plus the 64-bit engine command
  typedef struct packed {
    logic [3:0]  chan;
    logic [63:0] cmd;
  } cmd_t;

  // status FIFO entry
  typedef struct packed {
    logic        tmo;
    logic [3:0]  chan;
    logic [63:0] data;
  } stat_t;

endpackage

// File: rtl/pdp8lfpi2cq_fifo.sv
// Synchronous FIFO with simultaneous push/pop, flush, full/empty/count.
// A push while full is accepted only when a pop happens in the same cycle.
module pdp8lfpi2cq_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 8
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLCNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULLCNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // storage write; contents need no reset, empty gates every read
  always_ff @(posedge CLOCK)
    if (do_push) mem[wptr] <= din;

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge CLOCK) begin
    if (RESET || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pdp8lfpi2cq.sv
// Queued multi-channel front-panel I2C controller. Buffers engine commands,
// issues them one at a time to the i2cmaster engine, steers the engine onto
// the selected bus and queues the resulting status words for the ARM.
// Optional engine-busy watchdog: define PDP8LFPI2CQ_WATCHDOG_EN.
module pdp8lfpi2cq
  import pdp8lfpi2cq_pkg::*;
#(
  parameter int NCHAN  = 2,
  parameter int DEPTH  = 8,
  parameter int TMOCYC = 1000000
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              armwrite,
  input  logic [2:0]        armraddr,
  input  logic [2:0]        armwaddr,
  input  logic [31:0]       armwdata,
  output logic [31:0]       armrdata,
  output logic [63:0]       eng_cmd,
  output logic              eng_go,
  output logic              eng_reset,
  input  logic              eng_busy,
  input  logic [63:0]       eng_status,
  input  logic              eng_sclo,
  input  logic              eng_sdao,
  output logic              eng_sdai,
  output logic [NCHAN-1:0]  i2cclk,
  output logic [NCHAN-1:0]  i2cdao,
  input  logic [NCHAN-1:0]  i2cdai
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            wr_lo, wr_push, wr_spop, wr_ctl, clr;
  logic [31:0]     lo_q;
  logic [3:0]      nextchan, actchan;
  logic            manual, manclk, mandao, cmdovf, statovf, rst_q;
  state_t          state;
  cmd_t            cmd_din, cmd_head;
  stat_t           stat_din, stat_head;
  logic            cmd_pop, cmd_full, cmd_empty;
  logic            stat_push, stat_full, stat_empty;
  logic [CW-1:0]   cmd_cnt, stat_cnt;
  logic            done, tmo;
  logic [NCHAN-1:0] actsel;

  assign wr_lo   = armwrite && (armwaddr == REG_CMDLO);
  assign wr_push = armwrite && (armwaddr == REG_CMDHI);
  assign wr_spop = armwrite && (armwaddr == REG_STHI);
  assign wr_ctl  = armwrite && (armwaddr == REG_CTL);
  assign clr     = wr_ctl && armwdata[0];

  assign cmd_din = {nextchan, armwdata, lo_q};
  assign cmd_pop = (state == S_ISSUE);

  // the status word is taken the first cycle busy is seen low, so the entry
  // lands in the FIFO on the edge into CAPT; CAPT is the turnaround cycle
  assign done      = (state == S_WAITLO) && !eng_busy;
  assign stat_push = done || tmo;
  assign stat_din  = {tmo, actchan, tmo ? 64'h0 : eng_status};

  assign eng_reset = RESET || rst_q;

`ifdef PDP8LFPI2CQ_WATCHDOG_EN
  logic [31:0] wdcnt;
  logic        waiting;
  assign waiting = (state == S_WAITHI) || (state == S_WAITLO);
  // a normal completion in the same cycle beats the timeout
  assign tmo = waiting && !done && (wdcnt == 32'(TMOCYC - 1));

  // cycles spent waiting on the engine; zero outside the wait states
  always_ff @(posedge CLOCK)
    if (RESET || clr || !waiting) wdcnt <= '0;
    else                          wdcnt <= wdcnt + 1'b1;
`else
  logic [31:0] unused_tmocyc;
  assign unused_tmocyc = TMOCYC;
  assign tmo = 1'b0;
`endif

  pdp8lfpi2cq_fifo #(.WIDTH(68), .DEPTH(DEPTH)) u_cmdq (
    .CLOCK(CLOCK), .RESET(RESET), .clr(clr),
    .push(wr_push), .pop(cmd_pop), .din(cmd_din), .dout(cmd_head),
    .full(cmd_full), .empty(cmd_empty), .count(cmd_cnt)
  );

  pdp8lfpi2cq_fifo #(.WIDTH(69), .DEPTH(DEPTH)) u_statq (
    .CLOCK(CLOCK), .RESET(RESET), .clr(clr),
    .push(stat_push), .pop(wr_spop), .din(stat_din), .dout(stat_head),
    .full(stat_full), .empty(stat_empty), .count(stat_cnt)
  );

  // ARM-visible control/config registers and sticky overflow flags
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      lo_q     <= '0;
      nextchan <= '0;
      manual   <= 1'b0;
      manclk   <= 1'b1;
      mandao   <= 1'b1;
      cmdovf   <= 1'b0;
      statovf  <= 1'b0;
      rst_q    <= 1'b0;
    end else begin
      rst_q <= clr || tmo;
      if (wr_lo) lo_q <= armwdata;
      if (wr_ctl) begin
        manual   <= armwdata[3];
        nextchan <= (32'(armwdata[11:8]) < NCHAN) ? armwdata[11:8] : 4'h0;
        manclk   <= armwdata[31];
        mandao   <= armwdata[30];
      end
      if (clr) begin
        cmdovf  <= 1'b0;
        statovf <= 1'b0;
      end else begin
        if (wr_push && cmd_full && !cmd_pop)    cmdovf  <= 1'b1;
        if (stat_push && stat_full && !wr_spop) statovf <= 1'b1;
      end
    end
  end

  // command sequencer; eng_cmd/actchan are latched on the way into ISSUE
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= S_IDLE;
      eng_go  <= 1'b0;
      eng_cmd <= '0;
      actchan <= '0;
    end else if (clr) begin
      state  <= S_IDLE;
      eng_go <= 1'b0;
    end else begin
      eng_go <= 1'b0;
      unique case (state)
        S_IDLE:
          if (!cmd_empty && !eng_busy && !manual) begin
            state   <= S_ISSUE;
            eng_go  <= 1'b1;
            eng_cmd <= cmd_head.cmd;
            actchan <= cmd_head.chan;
          end
        S_ISSUE:  state <= S_WAITHI;
        S_WAITHI:
          if (tmo)           state <= S_IDLE;
          else if (eng_busy) state <= S_WAITLO;
        S_WAITLO:
          if (done)          state <= S_CAPT;
          else if (tmo)      state <= S_IDLE;
        S_CAPT:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // bus steering: manual owns nextchan, otherwise the engine owns actchan
  for (genvar i = 0; i < NCHAN; i++) begin : g_bus
    logic man_sel, eng_sel;
    assign man_sel   = manual && (nextchan == 4'(i));
    assign eng_sel   = !manual && (actchan == 4'(i));
    assign actsel[i] = (actchan == 4'(i));
    assign i2cclk[i] = man_sel ? manclk : (eng_sel ? eng_sclo : 1'b1);
    assign i2cdao[i] = man_sel ? mandao : (eng_sel ? eng_sdao : 1'b1);
  end

  assign eng_sdai = |(actsel & i2cdai);

  // register read mux
  always_comb begin
    armrdata = '0;
    case (armraddr)
      REG_ID:   armrdata = ID_WORD;
      REG_STLO: if (!stat_empty) armrdata = stat_head.data[31:0];
      REG_STHI: if (!stat_empty) armrdata = stat_head.data[63:32];
      REG_CTL:  armrdata = {8'(cmd_cnt), 8'(stat_cnt), cmdovf, statovf,
                            state != S_IDLE, manual, nextchan, 8'h00};
      REG_HEAD: if (!stat_empty) armrdata = {1'b1, 26'b0, stat_head.tmo, stat_head.chan};
      REG_PAD:  armrdata = PAD_WORD;
      default:  armrdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pdp8lfpi2cq.sv
// Bench for pdp8lfpi2cq: directed ARM traffic plus a behavioural i2cmaster
// engine. Expected register reads, engine commands and point checks are
// queued by the stimulus; one monitor process compares them at negedge.
`timescale 1ns/1ps
module tb_pdp8lfpi2cq;
  localparam int NCHAN = 2, DEPTH = 8, TMOCYC = 20;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  logic             armwrite;
  logic [2:0]       armraddr, armwaddr;
  logic [31:0]      armwdata, armrdata;
  logic [63:0]      eng_cmd, eng_status;
  logic             eng_go, eng_reset, eng_busy, eng_sclo, eng_sdao, eng_sdai;
  logic [NCHAN-1:0] i2cclk, i2cdao, i2cdai;

  pdp8lfpi2cq #(.NCHAN(NCHAN), .DEPTH(DEPTH), .TMOCYC(TMOCYC)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
    .eng_cmd(eng_cmd), .eng_go(eng_go), .eng_reset(eng_reset),
    .eng_busy(eng_busy), .eng_status(eng_status), .eng_sclo(eng_sclo),
    .eng_sdao(eng_sdao), .eng_sdai(eng_sdai), .i2cclk(i2cclk),
    .i2cdao(i2cdao), .i2cdai(i2cdai)
  );

  typedef struct { string n; logic [31:0] exp; } rexp_t;
  typedef struct { string n; logic [63:0] act; logic [63:0] exp; } dchk_t;

  rexp_t       rq[$];
  logic [63:0] cq[$];
  dchk_t       dq[$];
  int rhead = 0, chead = 0, dhead = 0;
  int checks = 0, errors = 0, rstcnt = 0;
  logic rd_v = 1'b0;

  logic        eng_hold = 1'b0;
  int          busy_len = 5;
  logic [63:0] eng_next = '0;

  // monitor: sole owner of the counters and queue heads
  initial begin
    forever begin
      @(negedge CLOCK);
      if (rd_v) begin
        checks++;
        if (rhead >= rq.size()) begin
          errors++; $display("FAIL rd_unexpected got %h", armrdata);
        end else begin
          if (armrdata !== rq[rhead].exp) begin
            errors++;
            $display("FAIL %s got %h want %h", rq[rhead].n, armrdata, rq[rhead].exp);
          end
          rhead++;
        end
      end
      if (!RESET && eng_go) begin
        checks++;
        if (chead >= cq.size()) begin
          errors++; $display("FAIL go_unexpected got %h", eng_cmd);
        end else begin
          if (eng_cmd !== cq[chead]) begin
            errors++; $display("FAIL go_cmd%0d got %h want %h", chead, eng_cmd, cq[chead]);
          end
          chead++;
        end
      end
      if (!RESET && eng_reset) rstcnt++;
      while (dhead < dq.size()) begin
        checks++;
        if (dq[dhead].act !== dq[dhead].exp) begin
          errors++;
          $display("FAIL %s got %h want %h", dq[dhead].n, dq[dhead].act, dq[dhead].exp);
        end
        dhead++;
      end
    end
  end

  // behavioural engine: busy one cycle after go, for busy_len cycles
  // (longer while eng_hold), then presents eng_next as status
  initial begin
    eng_busy = 1'b0;
    eng_status = '0;
    forever begin
      @(negedge CLOCK);
      if (eng_go && !RESET) begin
        @(posedge CLOCK); #1 eng_busy = 1'b1;
        repeat (busy_len) @(posedge CLOCK);
        while (eng_hold) @(posedge CLOCK);
        #1 eng_status = eng_next; eng_busy = 1'b0;
      end
    end
  end

  // absolute time limit
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    dchk_t d;
    d.n = n; d.act = act; d.exp = exp;
    dq.push_back(d);
  endtask

  // all tasks start and end at posedge+1
  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    armwrite = 1'b1; armwaddr = a; armwdata = d;
    cyc(1);
    armwrite = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    rexp_t r;
    r.n = n; r.exp = e;
    rq.push_back(r);
    armraddr = a; rd_v = 1'b1;
    cyc(1);
    rd_v = 1'b0;
  endtask

  initial begin
    int r0;
    bit got;
    armwrite = 0; armraddr = 0; armwaddr = 0; armwdata = 0;
    eng_sclo = 1; eng_sdao = 1; i2cdai = '1;

    // reset
    cyc(3);
    chk("rst_engreset", 64'(eng_reset), 64'd1);
    chk("rst_go", 64'(eng_go), 64'd0);
    chk("rst_cmd", eng_cmd, 64'd0);
    RESET = 1'b0;
    cyc(1);
    chk("engreset_low", 64'(eng_reset), 64'd0);
    rd(3'd0, 32'h46502010, "rd_id");
    rd(3'd5, 32'h0, "rd_ctl_reset");
    rd(3'd6, 32'h0, "rd_head_reset");
    rd(3'd3, 32'h0, "rd_stlo_empty");
    rd(3'd7, 32'hDEADBEEF, "rd_pad");
    chk("rst_i2cclk", 64'(i2cclk), 64'd3);
    chk("rst_i2cdao", 64'(i2cdao), 64'd3);

    // single transaction on channel 1
    wr(3'd5, 32'h100);
    rd(3'd5, 32'h100, "rd_nextchan1");
    busy_len = 5; eng_next = 64'hABCD;
    cq.push_back(64'h00000022_00000011);
    wr(3'd1, 32'h11);
    wr(3'd2, 32'h22);
    armraddr = 3'd6; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      cyc(1);
      got = armrdata[31];
    end
    chk("t1_status_arrived", 64'(got), 64'd1);
    rd(3'd3, 32'h0000ABCD, "t1_stlo");
    rd(3'd4, 32'h0, "t1_sthi");
    rd(3'd6, 32'h80000001, "t1_head");
    rd(3'd5, 32'h00010100, "t1_ctl");
    wr(3'd4, 32'h0);
    rd(3'd6, 32'h0, "t1_head_popped");
    rd(3'd5, 32'h100, "t1_ctl_popped");
    wr(3'd5, 32'h500);
    rd(3'd5, 32'h0, "nextchan_clamp");

    // overflow: engine held busy, 10 pushes; cmd0 issues, 1..8 queue, 9 drops
    eng_hold = 1'b1; busy_len = 1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] hi, lo;
      lo = 32'(i); hi = 32'h100 + 32'(i);
      if (i < 9) cq.push_back({hi, lo});
      wr(3'd1, lo);
      wr(3'd2, hi);
    end
    rd(3'd5, 32'h0800A000, "ovf_ctl");
    eng_next = 64'h5555; busy_len = 3;
    eng_hold = 1'b0;
    for (int k = 0; k < 600 && chead < cq.size(); k++) cyc(1);
    chk("drain_done", 64'(chead), 64'(cq.size()));
    cyc(20);
    rd(3'd5, 32'h0008C000, "drain_ctl");
    rd(3'd3, 32'h00005555, "drain_stlo");
    rd(3'd6, 32'h80000000, "drain_head");
    wr(3'd5, 32'h1);
    rd(3'd5, 32'h0, "clr_ctl");
    rd(3'd6, 32'h0, "clr_head");

    // routing during a transaction on channel 0
    eng_hold = 1'b1; busy_len = 1;
    cq.push_back({32'h7, 32'h6});
    wr(3'd1, 32'h6);
    wr(3'd2, 32'h7);
    for (int k = 0; k < 20 && !eng_busy; k++) cyc(1);
    chk("rt_busy", 64'(eng_busy), 64'd1);
    cyc(3);
    i2cdai = 2'b01; #1;
    chk("rt_sdai_bus0_hi", 64'(eng_sdai), 64'd1);
    i2cdai = 2'b10; #1;
    chk("rt_sdai_bus0_lo", 64'(eng_sdai), 64'd0);
    chk("rt_clk_idle", 64'(i2cclk), 64'd3);
    eng_sclo = 0; eng_sdao = 0; #1;
    chk("rt_clk_bus0", 64'(i2cclk), 64'd2);
    chk("rt_dao_bus0", 64'(i2cdao), 64'd2);
    eng_sclo = 1; eng_sdao = 1; i2cdai = 2'b11;
    wr(3'd5, 32'h40000108);
    chk("man_clk", 64'(i2cclk), 64'd1);
    chk("man_dao", 64'(i2cdao), 64'd3);
    rd(3'd5, 32'h00003100, "man_ctl");
    wr(3'd5, 32'h0);

    // clear while in WAITLO
    r0 = rstcnt;
    wr(3'd5, 32'h1);
    cyc(3);
    chk("clr_rstpulse", 64'(rstcnt - r0), 64'd1);
    rd(3'd5, 32'h0, "clr_wait_ctl");
    eng_hold = 1'b0;
    cyc(15);
    rd(3'd6, 32'h0, "clr_no_status");
    rd(3'd5, 32'h0, "clr_idle_ctl");

`ifdef PDP8LFPI2CQ_WATCHDOG_EN
    // watchdog: engine never finishes
    eng_hold = 1'b1; busy_len = 1;
    r0 = rstcnt;
    cq.push_back({32'h9, 32'h8});
    wr(3'd1, 32'h8);
    wr(3'd2, 32'h9);
    cyc(40);
    chk("wd_rstpulse", 64'(rstcnt - r0), 64'd1);
    rd(3'd6, 32'h80000010, "wd_head");
    rd(3'd3, 32'h0, "wd_stlo");
    rd(3'd4, 32'h0, "wd_sthi");
    rd(3'd5, 32'h00010000, "wd_ctl");
    eng_hold = 1'b0;
    cyc(10);
`endif

    cyc(3);
    chk("rd_all_seen", 64'(rhead), 64'(rq.size()));
    chk("go_all_seen", 64'(chead), 64'(cq.size()));
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdp8lfpi2cq.md
# pdp8lfpi2cq

Queued, multi-channel front-panel I2C controller for the PDP-8/L Zynq design. Sits between the ARM register bus and one external I2C bit engine, which is an `i2cmaster` instance. It buffers 64-bit engine commands in a command FIFO and hands them to the engine one at a time. Each command is steered to one of NCHAN front-panel I2C buses, and each 64-bit engine status is captured into a status FIFO, so ARM software can batch transactions instead of polling each one.

## Interface
- NCHAN, 2, number of I2C buses (1..16)
- DEPTH, 8, entries per FIFO (power of 2, 2..128)
- TMOCYC, 1000000, engine-busy watchdog limit in CLOCK cycles (used only with the watchdog macro)
- CLOCK  in  1  system clock
- RESET  in  1  reset; synchronous, active-high; clock CLOCK
- armwrite  in  1  one-cycle register write strobe
- armraddr, armwaddr  in  3  register read/write index
- armwdata  in  32  write data
- armrdata  out  32  read data, combinational from armraddr
- eng_cmd  out  64  command presented to engine
- eng_go  out  1  one-cycle start pulse (engine `wrcmd`)
- eng_reset  out  1  engine reset
- eng_busy  in  1  engine transaction in progress
- eng_status  in  64  engine status word
- eng_sclo, eng_sdao  in  1  engine clock/data outputs
- eng_sdai  out  1  data-in to engine, taken from the active channel
- i2cclk, i2cdao  out  NCHAN  per-bus clock/data outputs
- i2cdai  in  NCHAN  per-bus data input

## Operation
- Register 0 (read): 32'h46502010.
- Register 1 (write): stage the low word of the command.
- Register 2 (write): push {nextchan, armwdata, staged low word} into the command FIFO.
  - If the FIFO is full, the push is dropped and sticky `cmdovf` is set.
  - A push that coincides with an engine pop is always accepted.
- Registers 3 and 4 (read): low and high words of the status FIFO head; 0 when the FIFO is empty.
- Register 4 (write, any data): pop the status FIFO. Ignored when the FIFO is empty.
- Register 5 (read): [31:24] command count, [23:16] status count, [15] cmdovf, [14] statovf, [13] engine state != IDLE, [12] manual, [11:8] nextchan, [7:0] 0.
- Register 5 (write):
  - [0] clear: one-shot; flushes both FIFOs, clears sticky bits, returns the FSM to IDLE and pulses eng_reset for 1 cycle. Any in-flight status is discarded.
  - [3] manual.
  - [11:8] nextchan; values >= NCHAN are written as 0.
  - [31] manclk, [30] mandao.
- Register 6 (read): [31] status FIFO non-empty, [4] timeout flag of the head entry, [3:0] channel of the head entry.
- Registers 6 and 7 (write) are ignored. Register 7 reads 32'hDEADBEEF.
- FSM states:
  - IDLE → ISSUE when the command FIFO is non-empty, eng_busy=0 and manual=0.
  - ISSUE: pop the head entry, latch its channel as `actchan`, drive eng_cmd, assert eng_go for this cycle only → WAITHI.
  - WAITHI: wait for eng_busy=1 → WAITLO.
  - WAITLO: wait for eng_busy=0 → CAPT.
  - CAPT: push {timeout=0, actchan, eng_status} into the status FIFO → IDLE. If the status FIFO is full, the entry is dropped and sticky `statovf` is set. A status push coinciding with an ARM pop is always accepted.
- Bus routing:
  - When manual=0: i2cclk[actchan]=eng_sclo, i2cdao[actchan]=eng_sdao, eng_sdai=i2cdai[actchan]; all other buses are driven 1.
  - When manual=1: bus nextchan is driven by manclk/mandao and all other buses are driven 1. Setting manual does not abort a transaction already issued.
- Reset state: FIFOs empty; FSM in IDLE; actchan=0; nextchan=0; manual=0; sticky bits 0; eng_go=0; eng_cmd=0; eng_reset=1 while RESET is asserted; i2cclk and i2cdao all ones.

## Timing
- A push write in cycle N makes the entry visible in the count at N+1. When idle, eng_go is asserted at N+2.
- eng_status is sampled in the first cycle eng_busy is seen low in WAITLO. The entry is visible in registers 3/4/6 one cycle later.
- Register reads have zero latency. Register writes take effect the next cycle.
- FIFO pointers wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits wide.

## Configuration
- PDP8LFPI2CQ_WATCHDOG_EN defined:
  - A counter runs in WAITHI and WAITLO and resets to 0 on entry to ISSUE.
  - When it reaches TMOCYC, the block pulses eng_reset for 1 cycle, pushes {timeout=1, actchan, 64'h0} and returns to IDLE.
- Macro undefined: no counter; the FSM waits indefinitely, and the timeout bit always reads 0.

## Structure
- Shared package `pdp8lfpi2cq_pkg`:
  - register index constants;
  - the ID constant;
  - FSM state enumeration;
  - the status-entry struct {tmo, chan[3:0], data[63:0]}.
- Sub-module `pdp8lfpi2cq_fifo` (parameters WIDTH and DEPTH, synchronous, simultaneous push/pop, full/empty/count outputs), instantiated twice: 68-bit command FIFO and 69-bit status FIFO.

## Test plan
- Reset, then read register 0 → 32'h46502010. Read register 5 → 0. i2cclk/i2cdao all ones.
- Set nextchan=1, write 32'h11 to register 1 and 32'h22 to register 2 → eng_go pulses once with eng_cmd=64'h00000022_00000011. The engine model asserts busy for 5 cycles then returns 64'hABCD → register 3 reads 32'hABCD, register 6 reads {1, …, chan=1}.
- With DEPTH=8 and the engine held busy, push 10 commands → command count saturates at the maximum and cmdovf=1. Releasing the engine drains the queued commands in order.
- During a transaction on channel 0, toggle i2cdai[1] → eng_sdai follows i2cdai[0] only, and i2cclk[1]=1.
- Write clear while in WAITLO → both counts 0, FSM IDLE, eng_reset high for exactly 1 cycle, no status entry added.
- With the watchdog macro on and TMOCYC=20, hold eng_busy=1 → at the 20th cycle eng_reset pulses and the status head shows timeout=1 with data 0.
